mask_region_gate: RTL and testbench

Parametrised, pipelined mask-stream gate for the exposure/readout path.
- Supports N independent rectangular regions. Each region has inclusive row bounds and inclusive column-word bounds.
- Inside a matching region, the outgoing 16-bit mask word comes from mstream_in (or is blanked). Outside all regions it is mstream_default.
- Region configuration is double-buffered, so host writes never tear a frame in progress. New settings take effect only at frame_start.

---
 rtl/mask_pkg.sv | 21 ++
 rtl/mask_region_match.sv | 17 +
 rtl/mask_region_gate.sv | 144 ++++++++++++++
 tb/tb_mask_region_gate.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mask_pkg.sv
// Shared types for the mask region gate: per-region config record and mode encoding.
// Pure declarations; no timing or flow-control behaviour.
package mask_pkg;

    localparam int ROW_W_DEF  = 9;
    localparam int COL_W_DEF  = 6;
    localparam int DATA_W_DEF = 16;

    localparam logic MODE_PASS  = 1'b0;
    localparam logic MODE_BLANK = 1'b1;

    typedef struct packed {
        logic                 en;
        logic                 mode;
        logic [ROW_W_DEF-1:0] row_t;
        logic [ROW_W_DEF-1:0] row_b;
        logic [COL_W_DEF-1:0] col_l;
        logic [COL_W_DEF-1:0] col_r;
    } region_cfg_t;

endpackage

// File: rtl/mask_region_match.sv
// Single-region hit test: enabled and (row, col) inside the inclusive rectangle.
// Combinational, zero latency; no flow control.
module mask_region_match
    import mask_pkg::*;
(
    input  region_cfg_t          cfg,
    input  logic [ROW_W_DEF-1:0] rowadd,
    input  logic [COL_W_DEF-1:0] col,
    output logic                 hit
);

    // Inverted bounds simply never match; no wrap-around interpretation.
    assign hit = cfg.en
              && (rowadd >= cfg.row_t) && (rowadd <= cfg.row_b)
              && (col >= cfg.col_l) && (col <= cfg.col_r);

endmodule

// File: rtl/mask_region_gate.sv
// Gates a mask word stream through N prioritised rectangular regions with double-buffered config.
// Fixed 2-cycle latency valid_in -> valid_out; no backpressure, bubbles pass through.
module mask_region_gate
    import mask_pkg::*;
#(
    parameter int N_REGIONS     = 4,
    parameter int ROW_W         = ROW_W_DEF,
    parameter int COL_W         = COL_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int WORDS_PER_ROW = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_idx,
    input  logic                 cfg_en,
    input  logic                 cfg_mode,
    input  logic [ROW_W-1:0]     cfg_row_t,
    input  logic [ROW_W-1:0]     cfg_row_b,
    input  logic [COL_W-1:0]     cfg_col_l,
    input  logic [COL_W-1:0]     cfg_col_r,
    input  logic                 valid_in,
    input  logic [ROW_W-1:0]     rowadd,
    input  logic [DATA_W-1:0]    mstream_default,
    input  logic [DATA_W-1:0]    mstream_in,
    output logic                 valid_out,
    output logic [DATA_W-1:0]    mstream_out,
    output logic [N_REGIONS-1:0] region_hit,
    output logic                 cfg_pending
);

    localparam logic [3:0]       N_REG_L  = 4'(N_REGIONS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WORDS_PER_ROW - 1);

    region_cfg_t shadow [N_REGIONS];
    region_cfg_t active [N_REGIONS];
    region_cfg_t wr_cfg;
    logic        idx_ok;

    assign wr_cfg = '{en: cfg_en, mode: cfg_mode, row_t: cfg_row_t, row_b: cfg_row_b,
                      col_l: cfg_col_l, col_r: cfg_col_r};
    assign idx_ok = ({1'b0, cfg_idx} < N_REG_L);

    // A write landing on frame_start goes straight into the active bank as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REGIONS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            cfg_pending <= 1'b0;
        end else begin
            for (int i = 0; i < N_REGIONS; i++) begin
                if (cfg_we && cfg_idx == 3'(i))
                    shadow[i] <= wr_cfg;
                if (frame_start)
                    active[i] <= (cfg_we && cfg_idx == 3'(i)) ? wr_cfg : shadow[i];
            end
            if (frame_start)
                cfg_pending <= 1'b0;
            else if (cfg_we && idx_ok)
                cfg_pending <= 1'b1;
        end
    end

    logic [COL_W-1:0] col_cnt;
    logic [COL_W-1:0] col_cur;
    logic [ROW_W-1:0] last_row;

    assign col_cur = (frame_start || rowadd != last_row) ? '0 : col_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt  <= '0;
            last_row <= '0;
        end else if (valid_in) begin
            col_cnt  <= (col_cur == COL_LAST) ? '0 : col_cur + 1'b1;
            last_row <= rowadd;
        end else if (frame_start) begin
            col_cnt  <= '0;
        end
    end

    logic [N_REGIONS-1:0] hit_vec;
    logic [N_REGIONS-1:0] win;
    logic                 win_mode;

    for (genvar g = 0; g < N_REGIONS; g++) begin : g_match
        mask_region_match u_match (
            .cfg    (active[g]),
            .rowadd (rowadd),
            .col    (col_cur),
            .hit    (hit_vec[g])
        );
    end

    // Isolate the lowest set bit: lowest index has priority.
    assign win = hit_vec & (~hit_vec + N_REGIONS'(1));

    always_comb begin
        win_mode = MODE_PASS;
        for (int i = 0; i < N_REGIONS; i++)
            if (win[i]) win_mode = active[i].mode;
    end

    logic                 s1_vld;
    logic [N_REGIONS-1:0] s1_win;
    logic                 s1_mode;
    logic [DATA_W-1:0]    s1_in;
    logic [DATA_W-1:0]    s1_def;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld      <= 1'b0;
            s1_win      <= '0;
            s1_mode     <= MODE_PASS;
            s1_in       <= '0;
            s1_def      <= '0;
            valid_out   <= 1'b0;
            mstream_out <= '0;
            region_hit  <= '0;
        end else begin
            s1_vld <= valid_in;
            if (valid_in) begin
                s1_win  <= win;
                s1_mode <= win_mode;
                s1_in   <= mstream_in;
                s1_def  <= mstream_default;
            end
            valid_out <= s1_vld;
            if (s1_vld) begin
                region_hit <= s1_win;
                if (s1_win == '0)
                    mstream_out <= s1_def;
                else if (s1_mode == MODE_BLANK)
                    mstream_out <= '0;
                else
                    mstream_out <= s1_in;
            end
        end
    end

endmodule

// File: tb/tb_mask_region_gate.sv
// Bench for mask_region_gate: directed sequences, a boundary table and a randomized stream
// checked against a rule-level reference model.
module tb_mask_region_gate;

    localparam int N = 4;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic        cfg_en;
    logic        cfg_mode;
    logic [8:0]  cfg_row_t;
    logic [8:0]  cfg_row_b;
    logic [5:0]  cfg_col_l;
    logic [5:0]  cfg_col_r;
    logic        valid_in;
    logic [8:0]  rowadd;
    logic [15:0] mstream_default;
    logic [15:0] mstream_in;
    logic        valid_out;
    logic [15:0] mstream_out;
    logic [3:0]  region_hit;
    logic        cfg_pending;

    mask_region_gate #(
        .N_REGIONS(N), .ROW_W(9), .COL_W(6), .DATA_W(16), .WORDS_PER_ROW(20)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
        .cfg_row_t(cfg_row_t), .cfg_row_b(cfg_row_b),
        .cfg_col_l(cfg_col_l), .cfg_col_r(cfg_col_r),
        .valid_in(valid_in), .rowadd(rowadd),
        .mstream_default(mstream_default), .mstream_in(mstream_in),
        .valid_out(valid_out), .mstream_out(mstream_out),
        .region_hit(region_hit), .cfg_pending(cfg_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct { bit en; bit mode; int rt; int rb; int cl; int cr; } mcfg_t;
    mcfg_t m_sh [N];
    mcfg_t m_ac [N];
    int    m_last, m_cnt;
    bit    m_pend;
    bit          s1_v, o_v;
    logic [15:0] s1_d, o_d;
    logic [3:0]  s1_h, o_h;

    logic [15:0] got_dat [$];
    logic [3:0]  got_hit [$];

    typedef struct { int row; int col; logic [3:0] hit; int src; } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_at(input string nm, input int k, input logic [15:0] ed, input logic [3:0] eh);
        if (got_dat.size() > k) begin
            chk({nm, "_dat"}, 32'(got_dat[k]), 32'(ed));
            chk({nm, "_hit"}, 32'(got_hit[k]), 32'(eh));
        end else begin
            chk({nm, "_words"}, got_dat.size(), k + 1);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sh[i] = '{default: 0};
            m_ac[i] = '{default: 0};
        end
        m_last = 0; m_cnt = 0; m_pend = 0;
        s1_v = 0; s1_d = '0; s1_h = '0;
        o_v = 0; o_d = '0; o_h = '0;
    endtask

    // One clock: predict this cycle's word from the rules, advance, compare outputs.
    task automatic cycle();
        int col;
        bit found;
        logic [15:0] e_d;
        logic [3:0]  e_h;
        mcfg_t w;
        bit wr_ok;
        col = (frame_start || int'(rowadd) != m_last) ? 0 : m_cnt;
        found = 0; e_d = mstream_default; e_h = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && m_ac[i].en && int'(rowadd) >= m_ac[i].rt && int'(rowadd) <= m_ac[i].rb
                && col >= m_ac[i].cl && col <= m_ac[i].cr) begin
                found = 1;
                e_h = 4'(1 << i);
                e_d = m_ac[i].mode ? 16'h0000 : mstream_in;
            end
        end
        w = '{cfg_en, cfg_mode, int'(cfg_row_t), int'(cfg_row_b), int'(cfg_col_l), int'(cfg_col_r)};
        wr_ok = cfg_we && int'(cfg_idx) < N;
        @(posedge clk);
        if (s1_v) begin o_d = s1_d; o_h = s1_h; end
        o_v = s1_v;
        s1_v = valid_in; s1_d = e_d; s1_h = e_h;
        if (valid_in) begin
            m_cnt  = (col == 19) ? 0 : col + 1;
            m_last = int'(rowadd);
        end else if (frame_start) begin
            m_cnt = 0;
        end
        if (wr_ok) m_sh[int'(cfg_idx)] = w;
        if (frame_start) begin
            m_ac = m_sh;
            m_pend = 0;
        end else if (wr_ok) begin
            m_pend = 1;
        end
        #1;
        chk("valid_out", 32'(valid_out), 32'(o_v));
        chk("mstream_out", 32'(mstream_out), 32'(o_d));
        chk("region_hit", 32'(region_hit), 32'(o_h));
        chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
        if (valid_out) begin
            got_dat.push_back(mstream_out);
            got_hit.push_back(region_hit);
        end
        valid_in = 0; frame_start = 0; cfg_we = 0;
    endtask

    task automatic bub(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input int idx, input bit en, input bit mode, input int rt, input int rb,
                      input int cl, input int cr, input bit fs);
        cfg_we = 1; cfg_idx = 3'(idx); cfg_en = en; cfg_mode = mode;
        cfg_row_t = 9'(rt); cfg_row_b = 9'(rb); cfg_col_l = 6'(cl); cfg_col_r = 6'(cr);
        frame_start = fs;
        cycle();
    endtask

    task automatic fstart();
        frame_start = 1;
        cycle();
    endtask

    task automatic row_stream(input int row, input int n);
        got_dat.delete();
        got_hit.delete();
        for (int k = 0; k < n; k++) begin
            valid_in = 1; rowadd = 9'(row);
            mstream_in = 16'hA000 | 16'(k);
            mstream_default = 16'h5000 | 16'(k);
            cycle();
        end
        bub(2);
    endtask

    initial begin
        tbl[0] = '{4, 2, 4'b0000, 0};
        tbl[1] = '{5, 1, 4'b0000, 0};
        tbl[2] = '{5, 2, 4'b0001, 1};
        tbl[3] = '{5, 4, 4'b0001, 1};
        tbl[4] = '{5, 5, 4'b0000, 0};
        tbl[5] = '{6, 3, 4'b0001, 1};
        tbl[6] = '{7, 2, 4'b0001, 1};
        tbl[7] = '{7, 4, 4'b0001, 1};
        tbl[8] = '{8, 2, 4'b0000, 0};
        tbl[9] = '{8, 3, 4'b0000, 0};

        rst = 1; frame_start = 0; cfg_we = 0; cfg_idx = '0; cfg_en = 0; cfg_mode = 0;
        cfg_row_t = '0; cfg_row_b = '0; cfg_col_l = '0; cfg_col_r = '0;
        valid_in = 0; rowadd = '0; mstream_default = '0; mstream_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_out", 32'(valid_out), 0);
        chk("rst_mstream_out", 32'(mstream_out), 0);
        chk("rst_region_hit", 32'(region_hit), 0);
        chk("rst_cfg_pending", 32'(cfg_pending), 0);
        rst = 0;
        model_reset();

        // Latency: a lone word appears exactly two edges later, then output holds.
        valid_in = 1; rowadd = 9'd50; mstream_default = 16'h1234; mstream_in = 16'hBEEF;
        cycle();
        chk("lat_c1_valid", 32'(valid_out), 0);
        cycle();
        chk("lat_c2_valid", 32'(valid_out), 1);
        chk("lat_c2_dat", 32'(mstream_out), 32'h1234);
        cycle();
        chk("lat_c3_valid", 32'(valid_out), 0);
        chk("lat_c3_hold", 32'(mstream_out), 32'h1234);

        for (int r = 0; r < 3; r++) begin
            row_stream(r, 20);
            chk("t1_words", got_dat.size(), 20);
            chk_at("t1_first", 0, 16'h5000, 4'b0000);
            chk_at("t1_last", 19, 16'h5013, 4'b0000);
        end

        wr(0, 1, 0, 5, 7, 2, 4, 1);
        for (int t = 0; t < 10; t++) begin
            row_stream(tbl[t].row, 20);
            chk_at($sformatf("tbl%0d", t), tbl[t].col,
                   (tbl[t].src == 0) ? (16'h5000 | 16'(tbl[t].col)) :
                   (tbl[t].src == 1) ? (16'hA000 | 16'(tbl[t].col)) : 16'h0000,
                   tbl[t].hit);
        end

        wr(0, 1, 0, 0, 10, 0, 19, 0);
        wr(1, 1, 1, 3, 3, 0, 19, 0);
        fstart();
        row_stream(3, 20);
        chk_at("t3_prio", 5, 16'hA005, 4'b0001);
        wr(0, 0, 0, 0, 10, 0, 19, 1);
        row_stream(3, 20);
        chk_at("t3_blank", 5, 16'h0000, 4'b0010);

        wr(0, 1, 0, 20, 20, 0, 19, 0);
        chk("t4_pend_set", 32'(cfg_pending), 1);
        row_stream(20, 20);
        chk_at("t4_shadow_only", 3, 16'h5003, 4'b0000);
        chk("t4_pend_hold", 32'(cfg_pending), 1);
        fstart();
        chk("t4_pend_clr", 32'(cfg_pending), 0);
        row_stream(20, 20);
        chk_at("t4_applied", 3, 16'hA003, 4'b0001);
        wr(0, 1, 1, 20, 20, 0, 19, 1);
        chk("t4_wt_pend", 32'(cfg_pending), 0);
        row_stream(20, 20);
        chk_at("t4_writethru", 3, 16'h0000, 4'b0001);

        wr(0, 0, 0, 0, 0, 0, 0, 0);
        wr(1, 1, 1, 9, 9, 0, 0, 0);
        wr(2, 1, 0, 9, 3, 0, 19, 0);
        wr(3, 1, 0, 0, 511, 10, 5, 0);
        wr(6, 1, 0, 0, 511, 0, 19, 0);
        fstart();
        row_stream(9, 25);
        chk("t5_words", got_dat.size(), 25);
        chk_at("t5_col0", 0, 16'h0000, 4'b0010);
        chk_at("t5_col19", 19, 16'h5013, 4'b0000);
        chk_at("t5_wrap", 20, 16'h0000, 4'b0010);
        chk_at("t5_after_wrap", 21, 16'h5015, 4'b0000);
        for (int k = 0; k < got_hit.size(); k++)
            chk("t5_empty_region", 32'(got_hit[k] & 4'b1100), 0);

        wr(0, 1, 0, 0, 511, 0, 19, 1);
        for (int k = 0; k < 5; k++) begin
            valid_in = 1; rowadd = 9'd30; mstream_in = 16'hC000 | 16'(k); mstream_default = 16'h7000;
            cycle();
        end
        valid_in = 1; rowadd = 9'd30;
        #3 rst = 1;
        #1;
        chk("t6_async_valid", 32'(valid_out), 0);
        chk("t6_async_dat", 32'(mstream_out), 0);
        chk("t6_async_hit", 32'(region_hit), 0);
        valid_in = 0;
        @(posedge clk);
        #1;
        chk("t6_flushed", 32'(valid_out), 0);
        rst = 0;
        model_reset();
        fstart();
        row_stream(30, 20);
        chk_at("t6_disabled", 0, 16'h5000, 4'b0000);
        chk_at("t6_disabled_end", 19, 16'h5013, 4'b0000);

        rowadd = 9'd0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                cfg_we = 1;
                cfg_idx = 3'($urandom_range(0, 7));
                cfg_en = 1'($urandom_range(0, 1));
                cfg_mode = 1'($urandom_range(0, 1));
                cfg_row_t = 9'($urandom_range(0, 15));
                cfg_row_b = 9'($urandom_range(0, 15));
                cfg_col_l = 6'($urandom_range(0, 21));
                cfg_col_r = 6'($urandom_range(0, 21));
            end
            if ($urandom_range(0, 39) == 0) begin
                frame_start = 1;
            end else begin
                valid_in = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 23) == 0) rowadd = 9'($urandom_range(0, 15));
                mstream_in = 16'($urandom);
                mstream_default = 16'($urandom);
            end
            cycle();
        end
        bub(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
